// File: rtl/cim_tile_model.sv
// ---------------------------------------------------------------------------
// cim_tile_model
//
// Behavioural compute-in-memory crossbar tile. It holds a square weight
// matrix and an input vector. An execute pulse runs a matrix-vector product
// one row per cycle into per-column accumulators. The accumulators are then
// shifted and quantised into a result buffer, which is read back one column
// at a time through a registered read port.
//
// Optional feature macro: CIM_TILE_SATURATE_EN
//   defined   -> quantisation clamps to the largest element value
//   undefined -> quantisation keeps the low bits (wrap-around)
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset (weights are not cleared)
//   i_wr_en    input-vector write strobe (ignored while busy)
//   i_wr_addr  input row index
//   i_wr_data  input element
//   i_wt_we    weight write strobe (ignored while busy)
//   i_wt_row   weight row
//   i_wt_col   weight column
//   i_wt_data  weight value
//   i_exec     single-cycle start pulse (ignored while busy)
//   o_busy     high while the product is being accumulated / quantised
//   i_rd_addr  result column index
//   o_data     quantised result of the column addressed on the previous cycle
// ---------------------------------------------------------------------------
module cim_tile_model #(
    parameter int xbar_size     = 512,
    parameter int datatype_size = 4,
    parameter int acc_width     = 2*datatype_size + $clog2(xbar_size),
    parameter int out_shift     = datatype_size
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_wr_en,
    input  logic [$clog2(xbar_size)-1:0]     i_wr_addr,
    input  logic [datatype_size-1:0]         i_wr_data,
    input  logic                             i_wt_we,
    input  logic [$clog2(xbar_size)-1:0]     i_wt_row,
    input  logic [$clog2(xbar_size)-1:0]     i_wt_col,
    input  logic [datatype_size-1:0]         i_wt_data,
    input  logic                             i_exec,
    output logic                             o_busy,
    input  logic [$clog2(xbar_size)-1:0]     i_rd_addr,
    output logic [datatype_size-1:0]         o_data
);

    localparam int addr_width = $clog2(xbar_size);
    localparam logic [addr_width-1:0] last_row = addr_width'(xbar_size - 1);
    localparam logic [acc_width-1:0]  q_max    = acc_width'((1 << datatype_size) - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, QUANT} state_t;

    state_t state;
    state_t next_state;

    logic [addr_width-1:0]    row_cnt;
    logic [datatype_size-1:0] in_buf  [xbar_size];
    logic [datatype_size-1:0] weights [xbar_size][xbar_size];
    logic [acc_width-1:0]     acc     [xbar_size];
    logic [datatype_size-1:0] res     [xbar_size];
    logic                     idle;

    // Full-width casts keep every accumulator bit referenced in both builds.
    function automatic logic [datatype_size-1:0] quant(input logic [acc_width-1:0] x);
`ifdef CIM_TILE_SATURATE_EN
        return (x > q_max) ? '1 : datatype_size'(x);
`else
        return datatype_size'(x);
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (i_exec) next_state = ACCUM;
            ACCUM:   if (row_cnt == last_row) next_state = QUANT;
            QUANT:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        idle   = (state == IDLE);
        o_busy = !idle;
    end

    // Weights carry no reset so a model survives a reset without reloading.
    always_ff @(posedge clk) begin
        if (idle && i_wt_we) begin
            weights[i_wt_row][i_wt_col] <= i_wt_data;
        end
    end

    // An input write in the same cycle as exec lands in in_buf before row 0
    // is read, so it is part of the product.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt <= '0;
            o_data  <= '0;
            for (int c = 0; c < xbar_size; c++) begin
                in_buf[c] <= '0;
                acc[c]    <= '0;
                res[c]    <= '0;
            end
        end else begin
            o_data <= res[i_rd_addr];
            case (state)
                IDLE: begin
                    if (i_wr_en) begin
                        in_buf[i_wr_addr] <= i_wr_data;
                    end
                    if (i_exec) begin
                        row_cnt <= '0;
                        for (int c = 0; c < xbar_size; c++) begin
                            acc[c] <= '0;
                        end
                    end
                end
                ACCUM: begin
                    for (int c = 0; c < xbar_size; c++) begin
                        acc[c] <= acc[c] + acc_width'(in_buf[row_cnt]) * acc_width'(weights[row_cnt][c]);
                    end
                    row_cnt <= (row_cnt == last_row) ? '0 : row_cnt + 1'b1;
                end
                QUANT: begin
                    for (int c = 0; c < xbar_size; c++) begin
                        res[c] <= quant(acc[c] >> out_shift);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cim_tile_model.sv
// ---------------------------------------------------------------------------
// tb_cim_tile_model
//
// Self-checking bench for cim_tile_model on an 8x8 tile with no output shift.
// A behavioural model computes every column sum directly and tracks the busy
// window as a countdown; a compare process checks o_busy and o_data against
// it on every falling edge. Directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_cim_tile_model;

    localparam int XS = 8;
    localparam int DW = 4;
    localparam int AW = 3;
`ifdef CIM_TILE_SATURATE_EN
    localparam int SAT_EXP = 15;
`else
    localparam int SAT_EXP = 8;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wt_we;
    logic [AW-1:0] wt_row;
    logic [AW-1:0] wt_col;
    logic [DW-1:0] wt_data;
    logic          exec;
    logic          busy;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    int n_compared   = 0;
    int n_mismatched = 0;
    bit check_en     = 1'b0;

    cim_tile_model #(
        .xbar_size(XS),
        .datatype_size(DW),
        .out_shift(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_wr_en(wr_en),
        .i_wr_addr(wr_addr),
        .i_wr_data(wr_data),
        .i_wt_we(wt_we),
        .i_wt_row(wt_row),
        .i_wt_col(wt_col),
        .i_wt_data(wt_data),
        .i_exec(exec),
        .o_busy(busy),
        .i_rd_addr(rd_addr),
        .o_data(rd_data)
    );

    always #5 clk = ~clk;

    // Reference model: plain arrays, a direct column sum and a busy countdown.
    logic [DW-1:0] m_in      [XS];
    logic [DW-1:0] m_w       [XS][XS];
    logic [DW-1:0] m_res     [XS];
    logic [DW-1:0] m_pending [XS];
    logic [DW-1:0] m_odata;
    int            m_busy_cnt = 0;

    function automatic logic [DW-1:0] quant_of(input int s);
`ifdef CIM_TILE_SATURATE_EN
        return (s > 15) ? 4'd15 : DW'(s);
`else
        return DW'(s % 16);
`endif
    endfunction

    function automatic logic [DW-1:0] col_result(input int c, input logic we,
                                                 input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        int sum = 0;
        int v;
        for (int r = 0; r < XS; r++) begin
            v = (we && wa == AW'(r)) ? int'(wd) : int'(m_in[r]);
            sum += v * int'(m_w[r][c]);
        end
        return quant_of(sum);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy_cnt <= 0;
            m_odata    <= '0;
            for (int i = 0; i < XS; i++) begin
                m_in[i]  <= '0;
                m_res[i] <= '0;
            end
        end else begin
            m_odata <= m_res[rd_addr];
            if (m_busy_cnt == 0) begin
                if (wr_en) m_in[wr_addr] <= wr_data;
                if (wt_we) m_w[wt_row][wt_col] <= wt_data;
                if (exec) begin
                    m_busy_cnt <= XS + 1;
                    for (int c = 0; c < XS; c++) begin
                        m_pending[c] <= col_result(c, wr_en, wr_addr, wr_data);
                    end
                end
            end else begin
                m_busy_cnt <= m_busy_cnt - 1;
                if (m_busy_cnt == 1) begin
                    for (int c = 0; c < XS; c++) begin
                        m_res[c] <= m_pending[c];
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("model_busy", 32'(busy), 32'(m_busy_cnt != 0));
            checkOutput("model_data", 32'(rd_data), 32'(m_odata));
        end
    end

    task automatic applyStimulus(input logic r, input logic we, input logic [AW-1:0] wa,
                                 input logic [DW-1:0] wd, input logic wtw, input logic [AW-1:0] row,
                                 input logic [AW-1:0] col, input logic [DW-1:0] wtd,
                                 input logic ex, input logic [AW-1:0] ra);
        @(negedge clk);
        rst     = r;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        wt_we   = wtw;
        wt_row  = row;
        wt_col  = col;
        wt_data = wtd;
        exec    = ex;
        rd_addr = ra;
    endtask

    task automatic idleCycle(input int ra);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, AW'(ra));
    endtask

    task automatic writeIn(input int a, input int d);
        applyStimulus(0, 1, AW'(a), DW'(d), 0, 0, 0, 0, 0, 0);
    endtask

    task automatic writeWt(input int r, input int c, input int d);
        applyStimulus(0, 0, 0, 0, 1, AW'(r), AW'(c), DW'(d), 0, 0);
    endtask

    task automatic execWith(input logic we, input int a, input int d);
        applyStimulus(0, we, AW'(a), DW'(d), 0, 0, 0, 0, 1, 0);
    endtask

    // Counts busy cycles seen until o_busy is low, bounded at 40 cycles.
    task automatic waitIdle(output int cnt);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            idleCycle(0);
            if (!busy) break;
            cnt++;
        end
        if (cnt >= 40) checkOutput("busy_timeout", 32'(cnt), 32'd0);
    endtask

    task automatic readCol(input int c, input int expected, input string tag);
        idleCycle(c);
        idleCycle(c);
        checkOutput($sformatf("%s_col%0d", tag, c), 32'(rd_data), 32'(expected));
    endtask

    task automatic loadIdentity();
        for (int r = 0; r < XS; r++)
            for (int c = 0; c < XS; c++)
                writeWt(r, c, (r == c) ? 1 : 0);
    endtask

    initial begin
        int cnt;
        rst = 0; wr_en = 0; wr_addr = 0; wr_data = 0; wt_we = 0;
        wt_row = 0; wt_col = 0; wt_data = 0; exec = 0; rd_addr = 0;

        // Reset defaults
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_en = 1'b1;
        idleCycle(0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        for (int c = 0; c < XS; c++) readCol(c, 0, "reset");

        // Identity; in[5] arrives together with exec and must be included
        loadIdentity();
        for (int r = 0; r < XS; r++) if (r != 5) writeIn(r, r);
        execWith(1, 5, 5);
        waitIdle(cnt);
        checkOutput("identity_busy_window", 32'(cnt), 32'd9);
        for (int c = 0; c < XS; c++) readCol(c, c, "identity");

        // Saturation / wrap: column sum 8*15*15 = 1800
        for (int r = 0; r < XS; r++)
            for (int c = 0; c < XS; c++)
                writeWt(r, c, 15);
        for (int r = 0; r < XS; r++) writeIn(r, 15);
        execWith(0, 0, 0);
        waitIdle(cnt);
        for (int c = 0; c < XS; c++) readCol(c, SAT_EXP, "sat");

        // Busy lockout: writes and a second exec mid-ACCUM are ignored
        execWith(0, 0, 0);
        idleCycle(0);
        idleCycle(0);
        applyStimulus(0, 1, 0, 7, 1, 0, 0, 0, 1, 0);
        waitIdle(cnt);
        checkOutput("lockout_busy_window", 32'(cnt + 3), 32'd9);
        for (int k = 0; k < 4; k++) begin
            idleCycle(0);
            checkOutput("lockout_no_rebusy", 32'(busy), 32'd0);
        end
        readCol(0, SAT_EXP, "lockout");
        execWith(0, 0, 0);
        waitIdle(cnt);
        readCol(0, SAT_EXP, "lockout_rerun");

        // Read during busy returns the old result
        loadIdentity();
        writeIn(3, 5);
        execWith(0, 0, 0);
        waitIdle(cnt);
        readCol(3, 5, "rdbusy_first");
        writeIn(3, 9);
        execWith(0, 0, 0);
        idleCycle(3);
        idleCycle(3);
        idleCycle(3);
        checkOutput("rdbusy_flag", 32'(busy), 32'd1);
        checkOutput("rdbusy_old", 32'(rd_data), 32'd5);
        waitIdle(cnt);
        readCol(3, 9, "rdbusy_new");

        // Reset in the 4th busy cycle, then reuse the retained weights
        for (int r = 0; r < XS; r++) writeIn(r, r);
        execWith(0, 0, 0);
        idleCycle(0);
        idleCycle(0);
        idleCycle(0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idleCycle(0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        for (int c = 0; c < XS; c++) readCol(c, 0, "midreset");
        for (int r = 0; r < XS; r++) if (r != 0) writeIn(r, r + 2);
        execWith(0, 0, 0);
        waitIdle(cnt);
        readCol(0, 0, "reload");
        readCol(2, 4, "reload");
        readCol(7, 9, "reload");

        // Randomised runs with random pokes while busy
        for (int round = 0; round < 4; round++) begin
            for (int r = 0; r < XS; r++)
                for (int c = 0; c < XS; c++)
                    writeWt(r, c, int'($urandom_range(15)));
            for (int r = 0; r < XS; r++) writeIn(r, int'($urandom_range(15)));
            execWith(1'($urandom_range(1)), int'($urandom_range(XS - 1)), int'($urandom_range(15)));
            for (int k = 0; k < XS + 1; k++) begin
                applyStimulus(0, 1'($urandom_range(1)), AW'($urandom_range(XS - 1)),
                              DW'($urandom_range(15)), 1'($urandom_range(1)),
                              AW'($urandom_range(XS - 1)), AW'($urandom_range(XS - 1)),
                              DW'($urandom_range(15)), 1'($urandom_range(1)),
                              AW'($urandom_range(XS - 1)));
            end
            idleCycle(0);
            waitIdle(cnt);
            for (int c = 0; c < XS; c++) idleCycle(c);
            idleCycle(0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d compared", n_compared);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
